// File: rtl/adc_stream_tx_if.sv
// Bundle of the ADC capture controls/bus and the UART/status outputs of adc_stream_tx.
// The master side drives capture controls and the ADC bus; the slave side is the streamer.
interface adc_stream_tx_if #(
  parameter int ADC_W      = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             en;
  logic             clr_ovf;
  logic [ADC_W-1:0] AD_data_in;
  logic             adc_clk;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output en, clr_ovf, AD_data_in,
    input  adc_clk, tx, busy, overflow, fifo_level
  );

  modport slave (
    input  en, clr_ovf, AD_data_in,
    output adc_clk, tx, busy, overflow, fifo_level
  );
endinterface

// File: rtl/adc_stream_tx.sv
// ADC sample-clock generator, block averager, sample FIFO and 8N1 UART framer.
// Each averaged sample goes out as HEADER followed by ceil(ADC_W/8) bytes, MSB byte first.
module adc_stream_tx #(
  parameter int         ADC_W      = 8,
  parameter int         ADC_DIV    = 4,
  parameter int         AVG_LOG2   = 0,
  parameter int         FIFO_DEPTH = 16,
  parameter int         BAUD_DIV   = 434,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input logic             clk,
  input logic             n_rst,
  adc_stream_tx_if.slave  bus
);

  localparam int NB     = (ADC_W + 7) / 8;
  localparam int EXT_W  = 8 * NB;
  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DIV_W  = $clog2(ADC_DIV);
  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ADC_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(ADC_DIV / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } tx_state_e;

  function automatic logic [ADC_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] sh;
    sh = s >> AVG_LOG2;
    return sh[ADC_W-1:0];
  endfunction

  function automatic logic [7:0] byte_sel(input logic [EXT_W-1:0] w,
                                          input logic [IDX_W-1:0] idx);
    logic [EXT_W-1:0] sh;
    sh = w >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  // ---------------- sample clock divider ----------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             adc_clk_q;
  logic             strobe;

  assign strobe    = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;

  // adc_clk follows the next divider value so it changes on the same edge as div_cnt.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      adc_clk_q <= (div_cnt_d >= DIV_HALF);
    end
  end

  // ---------------- block averager ----------------
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             last_smp;
  logic             res_vld;
  logic [ADC_W-1:0] res;

  assign sum      = acc_q + ACC_W'(bus.AD_data_in);
  assign last_smp = (smp_cnt_q == CNT_LAST);
  assign res_vld  = bus.en && strobe && last_smp;
  assign res      = avg_trunc(sum);

  always_comb begin
    acc_d     = acc_q;
    smp_cnt_d = smp_cnt_q;
    if (!bus.en) begin
      acc_d     = '0;
      smp_cnt_d = '0;
    end else if (strobe) begin
      if (last_smp) begin
        acc_d     = '0;
        smp_cnt_d = '0;
      end else begin
        acc_d     = sum;
        smp_cnt_d = smp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q     <= '0;
      smp_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // ---------------- sample FIFO ----------------
  logic [ADC_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic             fifo_full, fifo_empty;
  logic             pop, push, drop;
  tx_state_e        state_q, state_d;

  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push       = res_vld && (!fifo_full || pop);
  assign drop       = res_vld && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= res;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

  // ---------------- UART framer ----------------
  logic [EXT_W-1:0]  word_q, word_d;
  logic [8:0]        shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
    end
  end

  // bit_cnt 0 is the start bit, 1..8 data, 9 stop; the next byte's start follows with no gap.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          word_d     = EXT_W'(mem_q[rd_ptr_q]);
          shreg_d    = {1'b1, HEADER};
          tx_d       = 1'b0;
          bit_cnt_d  = '0;
          baud_cnt_d = '0;
          state_d    = ST_HDR;
        end
      end
      ST_HDR, ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            if (state_q == ST_HDR) begin
              state_d   = ST_DATA;
              idx_d     = IDX_LAST;
              shreg_d   = {1'b1, byte_sel(word_q, IDX_LAST)};
              tx_d      = 1'b0;
              bit_cnt_d = '0;
            end else if (idx_q == '0) begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end else begin
              idx_d     = idx_q - 1'b1;
              shreg_d   = {1'b1, byte_sel(word_q, idx_q - 1'b1)};
              tx_d      = 1'b0;
              bit_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[8:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.adc_clk    = adc_clk_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level_q;

endmodule

// File: doc/adc_stream_tx.md
# adc_stream_tx

Parametrised ADC capture and serial streaming block for the car's sensor path. It generates the ADC sample clock from the system clock, captures the parallel ADC bus on each sample strobe and averages blocks of samples. Each averaged sample is buffered in a FIFO and sent over an 8N1 UART as a framed packet: a header byte followed by the sample bytes. It is a self-contained successor to the single-byte capture/transmit path, with no vendor clock IP.

## Interface
- ADC_W, 8: ADC data width, 1..16.
- ADC_DIV, 4: system clocks per adc_clk period; even, ≥2.
- AVG_LOG2, 0: samples averaged per output = 2^AVG_LOG2; range 0..4.
- FIFO_DEPTH, 16: averaged-sample FIFO depth; power of two, ≥2.
- BAUD_DIV, 434: system clocks per UART bit (50 MHz / 115200).
- HEADER, 8'hA5: frame header byte.
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- en  in  1  capture enable; 0 = no FIFO pushes, accumulator held cleared.
- clr_ovf  in  1  single-cycle pulse clears overflow.
- AD_data_in  in  ADC_W  parallel ADC output bus.
- adc_clk  out  1  ADC sample clock, 50 % duty.
- tx  out  1  UART line, idle high.
- busy  out  1  UART frame in progress.
- overflow  out  1  sticky: an averaged sample was dropped because the FIFO was full.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Divider: div_cnt counts 0..ADC_DIV-1 and wraps. adc_clk is registered and is 1 when div_cnt ≥ ADC_DIV/2.
- Sample strobe: asserted in the cycle where div_cnt == ADC_DIV-1, i.e. coincident with the adc_clk falling edge. AD_data_in is registered on that clk edge.
- Accumulator: width ADC_W+AVG_LOG2, with a sample counter of 2^AVG_LOG2.
  - On each captured sample while en=1, the sample is added.
  - When the last sample of a block is added, the result is (sum >> AVG_LOG2), truncated. The accumulator and counter clear in the same cycle.
  - With AVG_LOG2=0, every sample is passed through unchanged.
  - With en=0, the accumulator and counter are held at 0. A partial block is discarded when en falls.
- FIFO push: the averaged result is pushed if the FIFO is not full. If it is full, the result is dropped and overflow is set.
  - overflow clears only on reset or clr_ovf.
  - If clr_ovf and a drop occur in the same cycle, overflow stays set.
- FIFO: synchronous read/write. A simultaneous push and pop when full or empty is legal: pop first, then push. The level is unchanged when both happen.
- Frame format: HEADER, then NB = ceil(ADC_W/8) data bytes, MSB byte first. The sample is zero-extended to 8·NB bits.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts BAUD_DIV clocks.
- TX FSM:
  - IDLE: tx=1, busy=0. If the FIFO is non-empty, pop one word, latch it and go to HDR.
  - HDR: shift out HEADER, then go to DATA with byte index NB-1.
  - DATA: shift out byte[idx]. If idx==0, go to IDLE; otherwise decrement idx.
- Back-to-back frames: IDLE re-evaluates the FIFO on the cycle after the last stop bit ends. There is no extra idle gap beyond that one cycle.
- en does not affect the TX FSM. Queued samples drain after en falls.

## Timing
- Reset values: adc_clk=0, tx=1, busy=0, overflow=0, fifo_level=0. div_cnt, accumulator, FSM (IDLE), baud counter and FIFO pointers all reset to 0.
- Reset mid-frame aborts immediately: tx=1 asynchronously and FIFO contents are discarded.
- Capture to push: the averaged result is pushed into the FIFO on the clk edge after the strobe cycle of the last sample in its block.
- Push to tx: the pop occurs 1 cycle after fifo_level becomes non-zero (when in IDLE), and tx falls (start bit) on the same edge that pops. busy rises with that edge.
- Frame length: (1+NB)·10·BAUD_DIV clocks. busy falls at the end of the final stop bit.
- Sustainable rate: 2^AVG_LOG2·ADC_DIV ≥ (1+NB)·10·BAUD_DIV clocks per sample. At faster rates the FIFO fills and overflow sets.

## Test plan
- Reset/idle: hold n_rst=0 for 5 cycles, then release with en=0. Expect tx=1, busy=0, fifo_level=0 and adc_clk toggling with period 4 (ADC_DIV=4).
- Single frame (ADC_W=8, AVG_LOG2=0, BAUD_DIV=8): set en=1 for one strobe with AD_data_in=8'h3C. Expect tx bits 0,10100101,1 then 0,00111100,1 (LSB first), 160 clocks of busy, and one push only.
- Averaging (AVG_LOG2=2): feed samples 10, 11, 12, 14. Expect one FIFO push of 11 (47>>2) after the 4th strobe.
- Wide data (ADC_W=12): feed sample 12'hABC. Expect bytes A5, 0A, BC on tx.
- Overflow (FIFO_DEPTH=2, BAUD_DIV=64, ADC_DIV=2): stream samples 1,2,3,4,… Expect fifo_level to saturate at 2 and overflow=1, the transmitted sequence to skip dropped values, and clr_ovf to clear overflow while no drop is occurring.
- Reset mid-frame: assert n_rst=0 during a DATA byte. Expect tx=1 immediately, and after release fifo_level=0 and no residual frame.
